// File: rtl/punc_exec_unit.sv
// rtl/punc_exec_unit.sv - PUnC execute/writeback unit: register file, ALU, shifts, NZP
// Define PUNC_EXEC_MUL_EN to build the iterative shift-add multiplier (op 6); otherwise op 6 is illegal.
module punc_exec_unit #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [2:0]                  op_code,
  input  logic [$clog2(NUM_REGS)-1:0] op_dst,
  input  logic [$clog2(NUM_REGS)-1:0] op_src0,
  input  logic [$clog2(NUM_REGS)-1:0] op_src1,
  input  logic [WIDTH-1:0]            op_imm,
  input  logic                        op_use_imm,
  input  logic                        op_cc_ld,
  output logic                        res_valid,
  output logic [WIDTH-1:0]            res_data,
  output logic                        res_illegal,
  output logic                        n,
  output logic                        z,
  output logic                        p,
  output logic                        busy,
  input  logic [$clog2(NUM_REGS)-1:0] rf_debug_addr,
  output logic [WIDTH-1:0]            rf_debug_data
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = $clog2(WIDTH);

`ifdef PUNC_EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

  state_t            state, state_nx;
  logic [WIDTH-1:0]  rf [NUM_REGS];
  logic [WIDTH-1:0]  a_q, b_q, b_in;
  logic [2:0]        code_q;
  logic [AW-1:0]     dst_q;
  logic              cc_q;
  logic              accept;
  logic [WIDTH-1:0]  exec_res, wb_data;
  logic              exec_ill, wb_en, wb_ill;

`ifdef PUNC_EXEC_MUL_EN
  logic [WIDTH-1:0]  acc_q, mul_sum;
  logic [SW-1:0]     cnt_q;
  logic              mul_last;

  // A shifts left and B shifts right each cycle, so B[0] always selects the current partial product
  assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
  assign mul_last = (cnt_q == SW'(WIDTH - 1));
`endif

  assign b_in          = op_use_imm ? op_imm : rf[op_src1];
  assign accept        = op_valid && op_ready;
  assign busy          = ~op_ready;
  assign rf_debug_data = rf[rf_debug_addr];

  always_comb begin
    exec_res = '0;
    exec_ill = 1'b0;
    case (code_q)
      3'd0:    exec_res = a_q + b_q;
      3'd1:    exec_res = a_q & b_q;
      3'd2:    exec_res = ~a_q;
      3'd3:    exec_res = a_q;
      3'd4:    exec_res = a_q << b_q[SW-1:0];
      3'd5:    exec_res = $signed(a_q) >>> b_q[SW-1:0];
      default: exec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    op_ready = 1'b0;
    wb_en    = 1'b0;
    wb_ill   = 1'b0;
    wb_data  = exec_res;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
`ifdef PUNC_EXEC_MUL_EN
          state_nx = (op_code == 3'd6) ? S_MUL : S_EXEC;
`else
          state_nx = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        wb_en    = 1'b1;
        wb_ill   = exec_ill;
        state_nx = S_IDLE;
      end
`ifdef PUNC_EXEC_MUL_EN
      S_MUL: begin
        if (mul_last) begin
          wb_en    = 1'b1;
          wb_data  = mul_sum;
          state_nx = S_IDLE;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      a_q         <= '0;
      b_q         <= '0;
      code_q      <= '0;
      dst_q       <= '0;
      cc_q        <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_illegal <= 1'b0;
      n           <= 1'b0;
      z           <= 1'b0;
      p           <= 1'b0;
`ifdef PUNC_EXEC_MUL_EN
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
        a_q    <= rf[op_src0];
        b_q    <= b_in;
        code_q <= op_code;
        dst_q  <= op_dst;
        cc_q   <= op_cc_ld;
`ifdef PUNC_EXEC_MUL_EN
        acc_q  <= '0;
        cnt_q  <= '0;
`endif
      end
`ifdef PUNC_EXEC_MUL_EN
      if (state == S_MUL) begin
        acc_q <= mul_sum;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 1'b1;
      end
`endif
      // Illegal ops still strobe res_valid but leave the RF and NZP untouched
      if (wb_en) begin
        res_valid   <= 1'b1;
        res_illegal <= wb_ill;
        res_data    <= wb_ill ? '0 : wb_data;
        if (!wb_ill) begin
          rf[dst_q] <= wb_data;
          if (cc_q) begin
            n <= wb_data[WIDTH-1];
            z <= (wb_data == '0);
            p <= !wb_data[WIDTH-1] && (wb_data != '0);
          end
        end
      end
    end
  end
endmodule
